// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor controller: one difference bit per clock, LSB first,
// with a start/busy/done handshake and registered difference, borrow and zero flag.
module serial_sub_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             br_out,
    output logic             zero_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             brw_q, brw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             zero_q, zero_d;

    // Subtractor cell: two cascaded half subtractors feeding the borrow flop.
    logic             d_bit;
    logic             brw_nx;
    logic [WIDTH-1:0] r_nx;
    logic             last_bit;

    assign d_bit    = a_q[0] ^ b_q[0] ^ brw_q;
    assign brw_nx   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    assign r_nx     = {d_bit, r_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; combinational next-state logic uses blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Datapath next-state; result registers move only on the last RUN cycle.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        r_d    = r_q;
        brw_d  = brw_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        br_d   = br_q;
        zero_d = zero_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = a_in;
                    b_d   = b_in;
                    r_d   = '0;
                    brw_d = 1'b0;
                    cnt_d = '0;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = r_nx;
                brw_d = brw_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    diff_d = r_nx;
                    br_d   = brw_nx;
                    zero_d = (r_nx == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            brw_q  <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            br_q   <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            r_q    <= r_d;
            brw_q  <= brw_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            br_q   <= br_d;
            zero_q <= zero_d;
        end
    end

    assign diff_out = diff_q;
    assign br_out   = br_q;
    assign zero_out = zero_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: directed WIDTH=8 operations plus an exhaustive WIDTH=4
// sweep, with a queue of expected results consumed on each done pulse.
module tb_serial_sub_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, br8, zero8;
    logic [7:0] diff8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, br4, zero4;
    logic [3:0] diff4;

    typedef struct {
        logic [7:0] diff;
        logic       br;
        logic       zero;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start8),
        .a_in     (a8),
        .b_in     (b8),
        .busy     (busy8),
        .done     (done8),
        .diff_out (diff8),
        .br_out   (br8),
        .zero_out (zero8)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start4),
        .a_in     (a4),
        .b_in     (b4),
        .busy     (busy4),
        .done     (done4),
        .diff_out (diff4),
        .br_out   (br4),
        .zero_out (zero4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic exp_t model(input bit w4, input logic [7:0] a, input logic [7:0] b);
        exp_t       e;
        logic [7:0] mask;
        logic [7:0] am, bm;
        mask   = w4 ? 8'h0F : 8'hFF;
        am     = a & mask;
        bm     = b & mask;
        e.diff = (am - bm) & mask;
        e.br   = (am < bm);
        e.zero = (e.diff == 8'h00);
        return e;
    endfunction

    task automatic sample(input bit w4, output logic bz, output logic dn,
                          output logic [7:0] df, output logic br, output logic zr);
        if (w4) begin
            bz = busy4; dn = done4; df = {4'h0, diff4}; br = br4; zr = zero4;
        end else begin
            bz = busy8; dn = done8; df = diff8; br = br8; zr = zero8;
        end
    endtask

    task automatic compare_result(input string tag, input logic [7:0] df, input logic br,
                                  input logic zr);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_unexpected_done"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_diff"}, df, e.diff);
            check({tag, "_br"}, br, e.br);
            check({tag, "_zero"}, zr, e.zero);
        end
    endtask

    // One start pulse; checks result, latency, busy length and result stability.
    task automatic run_op(input bit w4, input logic [7:0] a, input logic [7:0] b, input string tag);
        int         w;
        int         lat;
        int         busy_cnt;
        logic       bz, dn, br, zr;
        logic [7:0] df, held_df;
        w        = w4 ? 4 : 8;
        lat      = 0;
        busy_cnt = 0;
        @(negedge clk);
        sample(w4, bz, dn, held_df, br, zr);
        if (w4) begin start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; end
        else    begin start8 = 1'b1; a8 = a;      b8 = b;      end
        sb.push_back(model(w4, a, b));
        for (int cyc = 1; cyc <= 2 * w + 4; cyc++) begin
            @(negedge clk);
            if (w4) begin start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); end
            else    begin start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); end
            sample(w4, bz, dn, df, br, zr);
            if (bz) busy_cnt++;
            if (dn) begin
                lat = cyc;
                break;
            end
            if (df !== held_df) check({tag, "_held_while_busy"}, df, held_df);
        end
        if (lat == 0) begin
            check({tag, "_done_timeout"}, 0, 1);
            void'(sb.pop_front());
        end else begin
            compare_result(tag, df, br, zr);
            check({tag, "_latency"}, lat, w + 1);
            @(negedge clk);
            sample(w4, bz, dn, df, br, zr);
            check({tag, "_busy_falls"}, {bz, dn}, 2'b00);
            check({tag, "_busy_cycles"}, busy_cnt, w + 1);
        end
    endtask

    initial begin
        int   ndone;
        logic any_done;

        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        check("rst8_busy", busy8, 0);
        check("rst8_done", done8, 0);
        check("rst8_diff", diff8, 0);
        check("rst8_br", br8, 0);
        check("rst8_zero", zero8, 0);
        check("rst4_outs", {busy4, done4, diff4, br4, zero4}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_start", {busy8, done8}, 2'b00);

        run_op(0, 8'h5A, 8'h21, "sub_5a_21");
        run_op(0, 8'h21, 8'h5A, "sub_21_5a");
        run_op(0, 8'h00, 8'hFF, "sub_00_ff");

        // Reset during bit 4: everything clears asynchronously, no done afterwards.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h12;
        sb.push_back(model(0, 8'h77, 8'h12));
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before_rst", busy8, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy8, 0);
        check("async_rst_done", done8, 0);
        check("async_rst_diff", diff8, 0);
        check("async_rst_br", br8, 0);
        check("async_rst_zero", zero8, 0);
        sb.delete();
        any_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            any_done = any_done | done8;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            any_done = any_done | done8 | busy8;
        end
        check("no_done_after_abort", any_done, 0);
        run_op(0, 8'h5A, 8'h21, "after_rst");

        run_op(0, 8'h3C, 8'h3C, "sub_3c_3c");
        run_op(0, 8'hFF, 8'h00, "sub_ff_00");

        // start held high with operands scrambled during RUN.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hC3; b8 = 8'h4E;
        sb.push_back(model(0, 8'hC3, 8'h4E));
        ndone = 0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (done8) begin
                ndone++;
                compare_result("held_start", diff8, br8, zero8);
                check("held_done_cycle", k, (ndone == 1) ? 9 : 19);
            end
            if (k == 10) check("held_idle_gap", busy8, 0);
            if (k == 11) check("held_reaccept", busy8, 1);
            if (k == 10) begin
                a8 = 8'h90; b8 = 8'h10;
                sb.push_back(model(0, 8'h90, 8'h10));
            end else begin
                if (k >= 11) start8 = 1'b0;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
        end
        check("held_done_count", ndone, 2);
        check("held_sb_drained", sb.size(), 0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(1, 8'(a), 8'(b), "w4_sweep");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller: sequences a single 1-bit subtractor cell (two cascaded half subtractors plus a borrow flop) across WIDTH-bit operands, LSB first, one bit per clock. It computes unsigned A − B with a start/busy/done handshake and returns the difference, the final borrow (A < B) and a zero flag. It sits between a requesting unit and the 1-bit subtractor datapath, replacing a WIDTH-bit parallel subtractor where area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, derived bit-counter width; not overridden by users.

Clock and reset:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.

Request side:
- start  in  1  request; sampled only in IDLE.
- a_in  in  WIDTH  minuend; captured on the accepting edge.
- b_in  in  WIDTH  subtrahend; captured on the accepting edge.

Status and result:
- busy  out  1  high in RUN and DONE.
- done  out  1  single-cycle pulse; high only in DONE.
- diff_out  out  WIDTH  A − B mod 2^WIDTH; registered and held until the next completion.
- br_out  out  1  final borrow (1 when A < B unsigned); held like diff_out.
- zero_out  out  1  1 when diff_out == 0; held like diff_out.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE with start=1: load shift registers A←a_in and B←b_in, clear R, set borrow flop brw=0 and cnt=0, go to RUN. IDLE with start=0: hold.
- RUN, each cycle:
  - d = A[0]^B[0]^brw.
  - brw ← (~A[0]&B[0]) | (~(A[0]^B[0])&brw).
  - A, B shift right by 1.
  - R ← {d, R[WIDTH-1:1]}.
  - cnt ← cnt+1.
- RUN when cnt == WIDTH−1 (last bit being processed):
  - diff_out ← {d, R[WIDTH-1:1]}.
  - br_out ← next brw.
  - zero_out ← (that value == 0).
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored in RUN and DONE; no queueing. a_in and b_in are don't-care outside the accepting edge.
- Arithmetic is unsigned modulo 2^WIDTH. The final borrow is the only overflow indication.
- Reset values: busy=0, done=0, diff_out=0, br_out=0, zero_out=0. Internal A, B, R, brw and cnt are all 0.
- zero_out is 0 out of reset, not 1. It is valid only after the first completion.
- Reset asserted mid-operation aborts immediately: all of the above return to reset values, no done pulse, and the partial result is discarded.

## Timing
- Edge E0 accepts start. Edges E1..EWIDTH process bits 0..WIDTH−1.
- diff_out, br_out and zero_out update at edge EWIDTH. done is high in the cycle after EWIDTH and falls at EWIDTH+1.
- Latency: WIDTH+1 clocks from the accepting edge to done high.
- busy rises after E0 and falls after EWIDTH+1, so it spans WIDTH+1 cycles.
- Minimum start-to-start spacing is WIDTH+2 clocks. start held continuously is re-accepted at the first IDLE cycle, i.e. edge EWIDTH+2.
- Result outputs change only at completion edges or at reset. They are stable while busy.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, a_in=0x5A, b_in=0x21, start pulse -> done at +9 clocks, diff_out=0x39, br_out=0, zero_out=0; busy high 9 cycles.
- a_in=0x21, b_in=0x5A -> diff_out=0xC7, br_out=1, zero_out=0. Then a_in=0x00, b_in=0xFF -> diff_out=0x01, br_out=1.
- a_in=b_in=0x3C -> diff_out=0x00, br_out=0, zero_out=1. Then 0xFF−0x00 -> diff_out=0xFF, zero_out=0.
- start held high, with a_in changed every cycle during RUN -> result uses only the operands from the accepting edge; second acceptance exactly WIDTH+2 clocks after the first; exactly one done per operation.
- rst_n pulsed low at bit 4 of an active operation -> busy, done, diff_out, br_out and zero_out are 0 immediately (asynchronous); no done pulse; the next start completes correctly.
- WIDTH=4, all 256 operand pairs -> diff_out == (a−b)&0xF and br_out == (a<b) for every pair; latency 5 clocks each.
